// File: rtl/axi_decerr_responder_pkg.sv
// Shared SoC definitions for the default (unmapped) crossbar port:
// AXI response encodings, the read-data filler pattern, the crossbar
// slave enumeration including the error port, and the error window.
package axi_decerr_responder_pkg;

    // AXI response encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Recognisable filler returned on every read beat of an unmapped access
    localparam logic [63:0] DECERR_RESP_DATA = 64'hBADC_AB1E_BADC_AB1E;

    // Crossbar slave ports; the error port is addressed explicitly by the rule table
    typedef enum logic [2:0] {
        XBAR_SLV_ROM    = 3'd0,
        XBAR_SLV_SRAM   = 3'd1,
        XBAR_SLV_PERIPH = 3'd2,
        XBAR_SLV_DRAM   = 3'd3,
        XBAR_SLV_ERR    = 3'd4
    } xbar_slv_e;

    localparam int unsigned XBAR_NR_SLAVES = 5;

    // Hole in the address map routed to the error port
    localparam logic [63:0] ERR_PORT_BASE = 64'h0000_0000_5000_0000;
    localparam logic [63:0] ERR_PORT_LEN  = 64'h0000_0000_3000_0000;

    // Write channel state
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Read channel state
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // True when an address falls inside the explicit error window
    function automatic logic in_err_window(input logic [63:0] addr);
        return (addr >= ERR_PORT_BASE) && (addr < (ERR_PORT_BASE + ERR_PORT_LEN));
    endfunction

endpackage

// File: rtl/axi_decerr_responder.sv
// AXI4 responder for the crossbar default port. Every accepted write is
// drained and answered with DECERR on B; every accepted read returns
// ar_len+1 beats of filler data with DECERR on R. A saturating counter
// tallies accepted requests and the most recent request address is kept
// for debug readout. Read and write paths are independent and each holds
// at most one outstanding transaction.
module axi_decerr_responder
    import axi_decerr_responder_pkg::*;
#(
    parameter int unsigned         IdWidth   = 6,
    parameter int unsigned         AddrWidth = 64,
    parameter int unsigned         DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData = DataWidth'(DECERR_RESP_DATA),
    parameter int unsigned         CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // write address
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    // write data
    input  logic                 w_last_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    // write response
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    // read address
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    // read data
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    // debug
    output logic [CntWidth-1:0]  err_cnt_o,
    output logic [AddrWidth-1:0] last_addr_o
);

    // Write path state and registered outputs
    wr_state_e            r_wr_state;
    logic                 r_aw_ready;
    logic                 r_w_ready;
    logic                 r_b_valid;
    logic [IdWidth-1:0]   r_b_id;

    // Read path state and registered outputs
    rd_state_e            r_rd_state;
    logic                 r_ar_ready;
    logic                 r_r_valid;
    logic                 r_r_last;
    logic [IdWidth-1:0]   r_r_id;
    logic [7:0]           r_beat_cnt;

    // Debug state
    logic [CntWidth-1:0]  r_err_cnt;
    logic [AddrWidth-1:0] r_last_addr;

    // Handshake qualifiers
    logic                 w_aw_hs;
    logic                 w_w_last_hs;
    logic                 w_b_hs;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic [1:0]           w_hs_inc;

    // Counter increment that clamps at all-ones instead of wrapping
    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] cur,
                                                    input logic [1:0]          inc);
        logic [CntWidth:0] sum;
        sum = {1'b0, cur} + (CntWidth+1)'(inc);
        if (sum[CntWidth]) begin
            return '1;
        end
        return sum[CntWidth-1:0];
    endfunction

    assign w_aw_hs     = aw_valid_i && r_aw_ready;
    assign w_w_last_hs = w_valid_i && r_w_ready && w_last_i;
    assign w_b_hs      = r_b_valid && b_ready_i;
    assign w_ar_hs     = ar_valid_i && r_ar_ready;
    assign w_r_hs      = r_r_valid && r_ready_i;
    assign w_hs_inc    = {1'b0, w_aw_hs} + {1'b0, w_ar_hs};

    // Write FSM: accept AW, swallow W beats up to wlast, then answer on B
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_state <= W_IDLE;
            r_aw_ready <= 1'b1;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_id     <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_b_id     <= aw_id_i;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_last_hs) begin
                        r_w_ready  <= 1'b0;
                        r_b_valid  <= 1'b1;
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_aw_ready <= 1'b1;
                    r_w_ready  <= 1'b0;
                    r_b_valid  <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: accept AR, then emit ar_len+1 beats; the counter is the
    // number of beats still to go after the current one, so it never wraps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_state <= R_IDLE;
            r_ar_ready <= 1'b1;
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
            r_r_id     <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_r_id     <= ar_id_i;
                        r_beat_cnt <= ar_len_i;
                        r_r_last   <= (ar_len_i == 8'd0);
                        r_r_valid  <= 1'b1;
                        r_ar_ready <= 1'b0;
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_beat_cnt == 8'd0) begin
                            r_r_valid  <= 1'b0;
                            r_r_last   <= 1'b0;
                            r_ar_ready <= 1'b1;
                            r_rd_state <= R_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt - 8'd1;
                            r_r_last   <= (r_beat_cnt == 8'd1);
                        end
                    end
                end
                default: begin
                    r_r_valid  <= 1'b0;
                    r_r_last   <= 1'b0;
                    r_ar_ready <= 1'b1;
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // Error statistics: count accepted requests, remember the latest address
    // (write address takes priority when both channels handshake together)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt   <= '0;
            r_last_addr <= '0;
        end else begin
            if (w_aw_hs || w_ar_hs) begin
                r_err_cnt <= sat_add(r_err_cnt, w_hs_inc);
            end
            if (w_aw_hs) begin
                r_last_addr <= aw_addr_i;
            end else if (w_ar_hs) begin
                r_last_addr <= ar_addr_i;
            end
        end
    end

    assign aw_ready_o  = r_aw_ready;
    assign w_ready_o   = r_w_ready;
    assign b_id_o      = r_b_id;
    assign b_resp_o    = RESP_DECERR;
    assign b_valid_o   = r_b_valid;

    assign ar_ready_o  = r_ar_ready;
    assign r_id_o      = r_r_id;
    assign r_data_o    = RespData;
    assign r_resp_o    = RESP_DECERR;
    assign r_last_o    = r_r_last;
    assign r_valid_o   = r_r_valid;

    assign err_cnt_o   = r_err_cnt;
    assign last_addr_o = r_last_addr;

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Testbench for axi_decerr_responder: randomized and directed traffic,
// expected B/R responses queued at request time and checked by monitors.
module tb_axi_decerr_responder;

    localparam int IDW = 6;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int CW  = 4;
    localparam int CNT_MAX = 15;
    localparam logic [63:0] EXP_DATA = 64'hBADC_AB1E_BADC_AB1E;

    logic           clk;
    logic           rst_ni;
    logic [IDW-1:0] aw_id_i;
    logic [AW-1:0]  aw_addr_i;
    logic           aw_valid_i;
    logic           aw_ready_o;
    logic           w_last_i;
    logic           w_valid_i;
    logic           w_ready_o;
    logic [IDW-1:0] b_id_o;
    logic [1:0]     b_resp_o;
    logic           b_valid_o;
    logic           b_ready_i;
    logic [IDW-1:0] ar_id_i;
    logic [AW-1:0]  ar_addr_i;
    logic [7:0]     ar_len_i;
    logic           ar_valid_i;
    logic           ar_ready_o;
    logic [IDW-1:0] r_id_o;
    logic [DW-1:0]  r_data_o;
    logic [1:0]     r_resp_o;
    logic           r_last_o;
    logic           r_valid_o;
    logic           r_ready_i;
    logic [CW-1:0]  err_cnt_o;
    logic [AW-1:0]  last_addr_o;

    axi_decerr_responder #(
        .IdWidth  (IDW),
        .AddrWidth(AW),
        .DataWidth(DW),
        .CntWidth (CW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .aw_id_i    (aw_id_i),
        .aw_addr_i  (aw_addr_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .w_last_i   (w_last_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .ar_id_i    (ar_id_i),
        .ar_addr_i  (ar_addr_i),
        .ar_len_i   (ar_len_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .r_id_o     (r_id_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_last_o   (r_last_o),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .err_cnt_o  (err_cnt_o),
        .last_addr_o(last_addr_o)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
    } rexp_t;

    logic [IDW-1:0] exp_b[$];
    rexp_t          exp_r[$];

    int n_vec = 0;
    int n_err = 0;
    int r_beats = 0;
    bit in_rst = 1'b1;
    int bmode = 0;   // 0: always ready, 1: random
    int rmode = 0;   // 0: always ready, 1: random, 2: toggle

    // Reference state: requests accepted since reset, most recent address
    int            model_n = 0;
    logic [AW-1:0] model_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Response-side readiness patterns
    initial begin
        b_ready_i = 1'b1;
        r_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b_ready_i = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rmode == 0)      r_ready_i = 1'b1;
            else if (rmode == 1) r_ready_i = 1'($urandom_range(0, 1));
            else                 r_ready_i = ~r_ready_i;
        end
    end

    // Monitor: compares every B/R handshake with the scoreboard queues
    initial begin
        bit             r_stall = 1'b0;
        bit             b_stall = 1'b0;
        logic [IDW-1:0] pr_id = '0;
        logic           pr_last = 1'b0;
        logic [DW-1:0]  pr_data = '0;
        logic [IDW-1:0] pb_id = '0;
        rexp_t          e;
        logic [IDW-1:0] eb;
        forever begin
            @(negedge clk);
            if (in_rst) begin
                r_stall = 1'b0;
                b_stall = 1'b0;
            end else begin
                if (exp_r.size() != 0) check("ar_ready_busy", 64'(ar_ready_o), 64'd0);
                if (r_stall) begin
                    check("r_valid_held", 64'(r_valid_o), 64'd1);
                    check("r_id_held", 64'(r_id_o), 64'(pr_id));
                    check("r_last_held", 64'(r_last_o), 64'(pr_last));
                    check("r_data_held", r_data_o, pr_data);
                end
                if (r_valid_o && r_ready_i) begin
                    if (exp_r.size() == 0) begin
                        check("r_unexpected_beat", 64'(r_valid_o), 64'd0);
                    end else begin
                        e = exp_r.pop_front();
                        check("r_id", 64'(r_id_o), 64'(e.id));
                        check("r_last", 64'(r_last_o), 64'(e.last));
                        check("r_data", r_data_o, EXP_DATA);
                        check("r_resp", 64'(r_resp_o), 64'd3);
                        r_beats++;
                    end
                end
                r_stall = r_valid_o && !r_ready_i;
                pr_id   = r_id_o;
                pr_last = r_last_o;
                pr_data = r_data_o;

                if (b_stall) begin
                    check("b_valid_held", 64'(b_valid_o), 64'd1);
                    check("b_id_held", 64'(b_id_o), 64'(pb_id));
                end
                if (b_valid_o && b_ready_i) begin
                    if (exp_b.size() == 0) begin
                        check("b_unexpected", 64'(b_valid_o), 64'd0);
                    end else begin
                        eb = exp_b.pop_front();
                        check("b_id", 64'(b_id_o), 64'(eb));
                        check("b_resp", 64'(b_resp_o), 64'd3);
                    end
                end
                b_stall = b_valid_o && !b_ready_i;
                pb_id   = b_id_o;
            end
        end
    end

    // All tasks start and end just after a rising edge
    task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input int nbeats, input bit early);
        int t;
        if (early) begin
            w_valid_i = 1'b1;
            w_last_i  = (nbeats == 1);
            repeat (2) begin
                @(negedge clk);
                check("w_ready_before_aw", 64'(w_ready_o), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        aw_id_i    = id;
        aw_addr_i  = addr;
        aw_valid_i = 1'b1;
        t = 0;
        @(negedge clk);
        while (!aw_ready_o && t < 300) begin
            t++;
            @(negedge clk);
        end
        check("aw_accept_timeout", 64'(aw_ready_o), 64'd1);
        @(posedge clk);
        #1;
        aw_valid_i = 1'b0;
        exp_b.push_back(id);
        for (int i = 0; i < nbeats; i++) begin
            w_valid_i = 1'b1;
            w_last_i  = (i == nbeats - 1);
            t = 0;
            @(negedge clk);
            while (!w_ready_o && t < 300) begin
                t++;
                @(negedge clk);
            end
            check("w_accept_timeout", 64'(w_ready_o), 64'd1);
            @(posedge clk);
            #1;
            w_valid_i = 1'b0;
            w_last_i  = 1'b0;
            if (i < nbeats - 1) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        check("b_latency", 64'(b_valid_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len);
        int    t;
        rexp_t e;
        ar_id_i    = id;
        ar_addr_i  = addr;
        ar_len_i   = len[7:0];
        ar_valid_i = 1'b1;
        t = 0;
        @(negedge clk);
        while (!ar_ready_o && t < 300) begin
            t++;
            @(negedge clk);
        end
        check("ar_accept_timeout", 64'(ar_ready_o), 64'd1);
        @(posedge clk);
        #1;
        ar_valid_i = 1'b0;
        for (int i = 0; i <= len; i++) begin
            e.id   = id;
            e.last = (i == len);
            exp_r.push_back(e);
        end
        @(negedge clk);
        check("r_latency", 64'(r_valid_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", 64'(t < 3000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        int exp_cnt;
        exp_cnt = (model_n > CNT_MAX) ? CNT_MAX : model_n;
        @(negedge clk);
        check({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(exp_cnt));
        check({tag, "_last_addr"}, last_addr_o, model_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            kind;
        logic [IDW-1:0] wid, rid;
        logic [AW-1:0] waddr, raddr;
        int            len, beats, start;

        rst_ni = 1'b0;
        aw_id_i = '0; aw_addr_i = '0; aw_valid_i = 1'b0;
        w_last_i = 1'b0; w_valid_i = 1'b0;
        ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; ar_valid_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", 64'(aw_ready_o), 64'd1);
        check("rst_ar_ready", 64'(ar_ready_o), 64'd1);
        check("rst_w_ready", 64'(w_ready_o), 64'd0);
        check("rst_b_valid", 64'(b_valid_o), 64'd0);
        check("rst_r_valid", 64'(r_valid_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_last_addr", last_addr_o, 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        in_rst = 1'b0;
        @(posedge clk);
        #1;

        // single-beat write
        do_write(6'h15, 64'h5000_0000, 1, 1'b0);
        wait_idle();
        model_n = 1; model_addr = 64'h5000_0000;
        check_regs("single_write");

        // four-beat read
        do_read(6'h2A, 64'h5800_0040, 3);
        wait_idle();
        model_n++; model_addr = 64'h5800_0040;
        check_regs("read_burst");

        // two-beat read under toggling backpressure
        rmode = 2;
        do_read(6'h07, 64'h5A00_0000, 1);
        wait_idle();
        rmode = 0;
        model_n++; model_addr = 64'h5A00_0000;
        check_regs("backpressure");

        // same-cycle AW and AR
        fork
            do_write(6'h01, 64'h6000_0000, 2, 1'b0);
            do_read(6'h02, 64'h7000_0000, 2);
        join
        wait_idle();
        model_n += 2; model_addr = 64'h6000_0000;
        check_regs("simultaneous");

        // randomized traffic with random backpressure
        bmode = 1; rmode = 1;
        for (int it = 0; it < 40; it++) begin
            kind  = $urandom_range(0, 2);
            wid   = IDW'($urandom);
            rid   = IDW'($urandom);
            waddr = {32'h0, 32'h5000_0000 | ($urandom & 32'h2FFF_FFF8)};
            raddr = {32'h0, 32'h5000_0000 | ($urandom & 32'h2FFF_FFF8)};
            len   = $urandom_range(0, 7);
            beats = $urandom_range(1, 4);
            case (kind)
                0: begin
                    do_write(wid, waddr, beats, 1'($urandom_range(0, 1)));
                    model_n++; model_addr = waddr;
                end
                1: begin
                    do_read(rid, raddr, len);
                    model_n++; model_addr = raddr;
                end
                default: begin
                    fork
                        do_write(wid, waddr, beats, 1'b0);
                        do_read(rid, raddr, len);
                    join
                    model_n += 2; model_addr = waddr;
                end
            endcase
            wait_idle();
            check_regs("random");
        end

        // reset in the middle of a 256-beat read
        bmode = 0; rmode = 0;
        start = r_beats;
        do_read(6'h3F, 64'h7FFF_FFF0, 255);
        begin
            int t = 0;
            while (r_beats < start + 10 && t < 100) begin
                @(posedge clk);
                t++;
            end
        end
        #2;
        in_rst = 1'b1;
        rst_ni = 1'b0;
        #1;
        check("midrst_r_valid", 64'(r_valid_o), 64'd0);
        check("midrst_r_last", 64'(r_last_o), 64'd0);
        check("midrst_ar_ready", 64'(ar_ready_o), 64'd1);
        check("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("midrst_last_addr", last_addr_o, 64'd0);
        exp_r.delete();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        in_rst = 1'b0;
        model_n = 0; model_addr = '0;
        @(posedge clk);
        #1;
        do_read(6'h11, 64'h5555_0000, 0);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        model_n = 1; model_addr = 64'h5555_0000;
        check_regs("after_reset");

        // drive the counter to its ceiling, including a clamped +2
        for (int i = 0; i < 6; i++) begin
            waddr = 64'h6100_0000 + 64'(i * 16);
            fork
                do_write(6'(i), waddr, 1, 1'b0);
                do_read(6'(i + 8), 64'h7100_0000, 0);
            join
            wait_idle();
            model_n += 2; model_addr = waddr;
        end
        check_regs("sat_13");
        do_write(6'h33, 64'h6200_0000, 1, 1'b0);
        wait_idle();
        model_n++; model_addr = 64'h6200_0000;
        check_regs("sat_14");
        for (int i = 0; i < 2; i++) begin
            fork
                do_write(6'h21, 64'h6300_0000, 1, 1'b0);
                do_read(6'h22, 64'h7300_0000, 1);
            join
            wait_idle();
            model_n += 2; model_addr = 64'h6300_0000;
            check_regs("sat_clamp");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
